// File: rtl/id_scoreboard_if.sv
// id_scoreboard_if: decode/execute/writeback signals of the register scoreboard
interface id_scoreboard_if #(parameter int STALL_CNT_W = 16);
  logic                   id_valid_i;
  logic [4:0]             id_rs1_i;
  logic [4:0]             id_rs2_i;
  logic                   id_use_rs1_i;
  logic                   id_use_rs2_i;
  logic [4:0]             id_rd_i;
  logic                   id_wr_i;
  logic                   ex_ready_i;
  logic                   flush_i;
  logic                   wb_valid_i;
  logic [4:0]             wb_rd_i;
  logic                   issue_o;
  logic                   stall_o;
  logic [31:0]            pending_o;
  logic [STALL_CNT_W-1:0] stall_cnt_o;
  logic                   err_o;
  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, id_rd_i, id_wr_i,
           ex_ready_i, flush_i, wb_valid_i, wb_rd_i,
    input  issue_o, stall_o, pending_o, stall_cnt_o, err_o
  );
  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, id_rd_i, id_wr_i,
           ex_ready_i, flush_i, wb_valid_i, wb_rd_i,
    output issue_o, stall_o, pending_o, stall_cnt_o, err_o
  );
endinterface

// File: rtl/id_scoreboard.sv
// id_scoreboard: per-register in-flight write counters gating decode issue
module id_scoreboard #(
  parameter int STALL_CNT_W = 16
) (
  input logic           clk,
  input logic           rst,
  id_scoreboard_if.slave sb
);
  logic [1:0]             cnt [32];
  logic                   hazard;
  logic                   inc;
  logic                   dec;
  logic                   bad;
  logic                   err;
  logic [31:0]            pending;
  logic [STALL_CNT_W-1:0] stall_cnt;
  // cnt[0] is held at zero, so x0 sources never hazard and x0 writebacks never decrement
  assign hazard = (sb.id_use_rs1_i && cnt[sb.id_rs1_i] != 2'd0) ||
                  (sb.id_use_rs2_i && cnt[sb.id_rs2_i] != 2'd0) ||
                  (sb.id_wr_i && cnt[sb.id_rd_i] == 2'd3);
  assign sb.issue_o = sb.id_valid_i && !sb.flush_i && !hazard && sb.ex_ready_i;
  assign sb.stall_o = sb.id_valid_i && !sb.flush_i && (hazard || !sb.ex_ready_i);
  assign inc = sb.issue_o && sb.id_wr_i && sb.id_rd_i != 5'd0;
  assign dec = sb.wb_valid_i && cnt[sb.wb_rd_i] != 2'd0;
  assign bad = sb.wb_valid_i && sb.wb_rd_i != 5'd0 && cnt[sb.wb_rd_i] == 2'd0;
  always_comb begin
    pending[0] = 1'b0;
    for (int i = 1; i < 32; i++) pending[i] = cnt[i] != 2'd0;
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 32; i++)
      cnt[i] <= (rst || i == 0) ? 2'd0 :
                cnt[i] + {1'b0, inc && sb.id_rd_i == 5'(i)} - {1'b0, dec && sb.wb_rd_i == 5'(i)};
    err <= !rst && (err || bad);
    stall_cnt <= rst ? '0 : stall_cnt + {{(STALL_CNT_W-1){1'b0}}, sb.stall_o && !(&stall_cnt)};
  end
  assign sb.pending_o   = pending;
  assign sb.err_o       = err;
  assign sb.stall_cnt_o = stall_cnt;
endmodule

// File: tb/tb_id_scoreboard.sv
// tb_id_scoreboard: directed scoreboard bench for id_scoreboard
module tb_id_scoreboard;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  id_scoreboard_if #(.STALL_CNT_W(4)) sb ();
  id_scoreboard #(.STALL_CNT_W(4)) dut (.clk(clk), .rst(rst), .sb(sb));
  typedef struct {
    string       tag;
    logic [63:0] v;
  } exp_t;
  exp_t q[$];
  int compared = 0;
  int mismatched = 0;
  int m_cnt [32];
  logic m_err;
  int m_sc;
  logic last_issue, last_stall;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(logic [63:0] obs);
    exp_t e;
    if (q.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = q.pop_front();
      chk(e.tag, obs, e.v);
    end
  endtask

  task automatic idle();
    rst = 1'b0;
    sb.id_valid_i = 1'b0; sb.id_rs1_i = 5'd0; sb.id_rs2_i = 5'd0;
    sb.id_use_rs1_i = 1'b0; sb.id_use_rs2_i = 1'b0;
    sb.id_rd_i = 5'd0; sb.id_wr_i = 1'b0; sb.ex_ready_i = 1'b1;
    sb.flush_i = 1'b0; sb.wb_valid_i = 1'b0; sb.wb_rd_i = 5'd0;
  endtask

  task automatic step();
    logic haz, iss, stl, inc, dec, bad;
    logic [31:0] p;
    haz = (sb.id_use_rs1_i && sb.id_rs1_i != 0 && m_cnt[sb.id_rs1_i] != 0) ||
          (sb.id_use_rs2_i && sb.id_rs2_i != 0 && m_cnt[sb.id_rs2_i] != 0) ||
          (sb.id_wr_i && sb.id_rd_i != 0 && m_cnt[sb.id_rd_i] == 3);
    iss = sb.id_valid_i && !sb.flush_i && !haz && sb.ex_ready_i;
    stl = sb.id_valid_i && !sb.flush_i && (haz || !sb.ex_ready_i);
    q.push_back('{tag: "issue", v: 64'(iss)});
    q.push_back('{tag: "stall", v: 64'(stl)});
    #1;
    last_issue = sb.issue_o;
    last_stall = sb.stall_o;
    pop_chk(64'(sb.issue_o));
    pop_chk(64'(sb.stall_o));
    inc = iss && sb.id_wr_i && sb.id_rd_i != 0;
    dec = sb.wb_valid_i && sb.wb_rd_i != 0 && m_cnt[sb.wb_rd_i] != 0;
    bad = sb.wb_valid_i && sb.wb_rd_i != 0 && m_cnt[sb.wb_rd_i] == 0;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_err = 1'b0;
      m_sc = 0;
    end else begin
      if (inc) m_cnt[sb.id_rd_i] = m_cnt[sb.id_rd_i] + 1;
      if (dec) m_cnt[sb.wb_rd_i] = m_cnt[sb.wb_rd_i] - 1;
      if (bad) m_err = 1'b1;
      if (stl && m_sc < 15) m_sc = m_sc + 1;
    end
    p = '0;
    for (int i = 1; i < 32; i++) p[i] = m_cnt[i] != 0;
    q.push_back('{tag: "pending", v: 64'(p)});
    q.push_back('{tag: "err", v: 64'(m_err)});
    q.push_back('{tag: "stall_cnt", v: 64'(m_sc)});
    #1;
    pop_chk(64'(sb.pending_o));
    pop_chk(64'(sb.err_o));
    pop_chk(64'(sb.stall_cnt_o));
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_err = 1'b0;
    m_sc = 0;
    idle();
    rst = 1'b1;
    @(negedge clk);
    step(); step();
    chk("rst_pending", 64'(sb.pending_o), 64'h0);
    chk("rst_err", 64'(sb.err_o), 64'h0);
    chk("rst_stall_cnt", 64'(sb.stall_cnt_o), 64'h0);
    // write x5, then a dependent read waits until the cycle after wb x5
    idle(); sb.id_valid_i = 1; sb.id_wr_i = 1; sb.id_rd_i = 5'd5; step();
    chk("x5_issue", 64'(last_issue), 64'h1);
    chk("x5_pending", 64'(sb.pending_o), 64'h20);
    idle(); sb.id_valid_i = 1; sb.id_use_rs1_i = 1; sb.id_rs1_i = 5'd5; step();
    chk("raw_stall", 64'(last_stall), 64'h1);
    step();
    sb.wb_valid_i = 1; sb.wb_rd_i = 5'd5; step();
    chk("no_bypass_stall", 64'(last_stall), 64'h1);
    chk("no_bypass_issue", 64'(last_issue), 64'h0);
    sb.wb_valid_i = 0; step();
    chk("raw_release", 64'(last_issue), 64'h1);
    // x0 is never tracked
    idle(); sb.id_valid_i = 1; sb.id_use_rs1_i = 1; sb.id_wr_i = 1; step();
    chk("x0_issue", 64'(last_issue), 64'h1);
    step();
    chk("x0_no_stall", 64'(last_stall), 64'h0);
    chk("x0_pending", 64'(sb.pending_o), 64'h0);
    idle(); sb.wb_valid_i = 1; step();
    chk("x0_wb_err", 64'(sb.err_o), 64'h0);
    // saturation at three in-flight writes to x7
    idle(); sb.id_valid_i = 1; sb.id_wr_i = 1; sb.id_rd_i = 5'd7;
    step(); step(); step();
    step();
    chk("x7_fourth_stall", 64'(last_stall), 64'h1);
    sb.wb_valid_i = 1; sb.wb_rd_i = 5'd7; step();
    chk("x7_wb_cycle_stall", 64'(last_stall), 64'h1);
    sb.wb_valid_i = 0; step();
    chk("x7_fourth_issue", 64'(last_issue), 64'h1);
    idle(); sb.wb_valid_i = 1; sb.wb_rd_i = 5'd7; step(); step();
    chk("x7_still_pending", 64'(sb.pending_o[7]), 64'h1);
    step();
    chk("x7_drained", 64'(sb.pending_o[7]), 64'h0);
    chk("x7_no_err", 64'(sb.err_o), 64'h0);
    // simultaneous issue and writeback of x9; stray writeback of x12
    idle(); sb.id_valid_i = 1; sb.id_wr_i = 1; sb.id_rd_i = 5'd9; step();
    sb.wb_valid_i = 1; sb.wb_rd_i = 5'd9; step();
    chk("x9_same_cycle_issue", 64'(last_issue), 64'h1);
    chk("x9_held", 64'(sb.pending_o[9]), 64'h1);
    idle(); sb.wb_valid_i = 1; sb.wb_rd_i = 5'd9; step();
    chk("x9_cleared", 64'(sb.pending_o[9]), 64'h0);
    chk("x9_no_err", 64'(sb.err_o), 64'h0);
    sb.wb_rd_i = 5'd12; step();
    chk("x12_err", 64'(sb.err_o), 64'h1);
    idle(); step();
    chk("err_sticky", 64'(sb.err_o), 64'h1);
    // flush, ex_ready stalls and reset mid-stall
    idle(); rst = 1; step();
    idle(); sb.id_valid_i = 1; sb.id_wr_i = 1; sb.id_rd_i = 5'd3; step(); step();
    chk("x3_pending", 64'(sb.pending_o), 64'h8);
    idle(); sb.wb_valid_i = 1; sb.wb_rd_i = 5'd12; step();
    chk("err_again", 64'(sb.err_o), 64'h1);
    idle(); sb.id_valid_i = 1; sb.id_use_rs1_i = 1; sb.id_rs1_i = 5'd3; sb.flush_i = 1; step();
    chk("flush_stall", 64'(last_stall), 64'h0);
    chk("flush_issue", 64'(last_issue), 64'h0);
    idle(); sb.id_valid_i = 1; sb.id_use_rs1_i = 1; sb.id_rs1_i = 5'd4; sb.ex_ready_i = 0;
    for (int i = 0; i < 9; i++) step();
    chk("ready_stall", 64'(last_stall), 64'h1);
    chk("stall_cnt_9", 64'(sb.stall_cnt_o), 64'd9);
    sb.id_rs1_i = 5'd3; sb.ex_ready_i = 1; step();
    chk("stall_cnt_10", 64'(sb.stall_cnt_o), 64'd10);
    rst = 1; sb.wb_valid_i = 1; sb.wb_rd_i = 5'd3; step();
    chk("rst_cycle_stall", 64'(last_stall), 64'h1);
    chk("rst_mid_pending", 64'(sb.pending_o), 64'h0);
    chk("rst_mid_stall_cnt", 64'(sb.stall_cnt_o), 64'h0);
    chk("rst_mid_err", 64'(sb.err_o), 64'h0);
    idle(); sb.id_valid_i = 1; sb.ex_ready_i = 0;
    for (int i = 0; i < 17; i++) step();
    chk("stall_cnt_sat", 64'(sb.stall_cnt_o), 64'hf);
    idle(); sb.wb_valid_i = 1; sb.wb_rd_i = 5'd3; step();
    chk("x3_after_rst_err", 64'(sb.err_o), 64'h1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
